calc_sequencer: RTL
===================

# calc_sequencer

Key-entry and execution controller for the two-digit decimal calculator datapath. Collects operand A, an operator and operand B from single-cycle key pulses and drives the datapath's operand-digit and operation-select inputs. Captures the 14-bit binary result and converts it to four BCD digits for the 7-segment display driver. The block sits between the keypad decoder and the calculator datapath and display.

## Interface
Parameters:
- none (operand width fixed at 2 decimal digits; result 14 bits / 4 BCD digits)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- key_valid  in  1  one-cycle pulse, key_code valid
- key_code  in  4  0–9 digit; 10 add, 11 sub, 12 mul, 13 div; 14 '='; 15 clear
- n2dig1, n2dig0  out  4 each  datapath left operand (datapath computes n2 op n1)
- n1dig1, n1dig0  out  4 each  datapath right operand
- op  out  2  00 add, 01 sub, 10 mul, 11 div
- num  in  14  datapath binary result (combinational from the outputs above)
- res3, res2, res1, res0  out  4 each  BCD result, res3 = thousands
- neg  out  1  result is negative (subtraction with A < B)
- busy  out  1  high in S_CALC and S_CONV
- done  out  1  one-cycle pulse on entry to S_DONE
- err  out  1  high in S_ERR (divide by zero)

## Operation
- Registers: A (2 BCD digits), B (2 BCD digits), op, swap, neg, bin (14 b), BCD shift register, conversion counter (4 b).
- States: S_A, S_B, S_CALC, S_CONV, S_DONE, S_ERR.
- Clear (code 15) accepted in every state: go to S_A; A, B, op, swap, neg, res*, err cleared. Clear takes priority over everything.
- S_A: digit shifts in: A.dig1 <= A.dig0, A.dig0 <= digit. Entering more than 2 digits keeps the last two. An operator latches op, clears B, and moves to S_B. '=' is ignored.
- S_B: digit shifts into B the same way. An operator with no B digit entered yet replaces op. An operator after a B digit is ignored. On '=':
  - If op = div and B = 00: go to S_ERR.
  - Otherwise go to S_CALC. Set swap = neg = (op = sub and A < B).
- Operand drive: swap = 0 gives n2 = A, n1 = B. swap = 1 gives n2 = B, n1 = A. op is driven from the op register at all times.
- S_CALC: one cycle; bin <= num; go to S_CONV with counter = 0.
- S_CONV: double-dabble, 14 iterations, one per cycle (add 3 to each BCD nibble ≥ 5, then shift left one bit). After iteration 14, load res3..res0 and go to S_DONE.
- S_DONE: results held.
  - A digit restarts entry: A = {0, digit}, B cleared, neg/swap cleared, state S_A.
  - Operator and '=' are ignored.
- S_ERR: res* = 0, err = 1. A digit behaves as in S_DONE and clears err. Other keys except clear are ignored.
- Keys other than clear during S_CALC/S_CONV are dropped (not queued).
- Arithmetic: max result 99*99 = 9801, which fits in 4 BCD digits. Division is floor. Subtraction is always non-negative after the swap.

## Timing
- Reset (async assert, sync deassert from system): state S_A; all outputs 0 (n*dig*, op, res*, neg, busy, done, err).
- Key sampled on the edge where key_valid = 1. The state change is visible after that edge.
- '=' sampled at edge E, normal path:
  - Edge E: state S_CALC, busy = 1.
  - Edge E+1: bin captured, S_CONV.
  - Edges E+2..E+15: 14 iterations.
  - Edge E+15: state S_DONE, res* valid, busy = 0, done = 1 for the cycle after E+15 only.
- '=' at edge E with div by 00: edge E gives S_ERR with err = 1; no busy, no done.
- Operand outputs are stable from edge E through S_CONV, so num is settled before the capture at E+1.
- Clear during S_CONV aborts the conversion. res* stay 0 and done does not pulse.

## Test plan
- Reset then keys 4,2,+,1,7,= -> n2 = 4/2, n1 = 1/7, op = 00; done pulses 16 edges after '='; res = 0,0,5,9, neg = 0.
- Keys 0,5,-,2,0,= -> swap = 1 (n2 = 2/0, n1 = 0/5), neg = 1, res = 0,0,1,5.
- Keys 9,9,*,9,9,= -> res = 9,8,0,1; keys 7,/,0,= -> err = 1 at next edge, res = 0, no done; key 3 clears err, A = 03.
- Keys 1,2,3 -> A = 23; +,* (no B digit) -> op = 10; 4,-,5 -> B = 45 (operator ignored); 23*45 gives res = 1,0,3,5.
- Keys during busy are ignored; clear at 5 cycles into S_CONV -> S_A next edge, busy = 0, no done pulse. rst_n low mid-S_CONV -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - key-entry, execution and BCD conversion controller for the two-digit calculator
module calc_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [3:0]  n2dig1,
  output logic [3:0]  n2dig0,
  output logic [3:0]  n1dig1,
  output logic [3:0]  n1dig0,
  output logic [1:0]  op,
  input  logic [13:0] num,
  output logic [3:0]  res3,
  output logic [3:0]  res2,
  output logic [3:0]  res1,
  output logic [3:0]  res0,
  output logic        neg,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {S_A, S_B, S_CALC, S_CONV, S_DONE, S_ERR} state_t;

  state_t      state, state_nx;
  logic [3:0]  a1, a0, b1, b0;
  logic [1:0]  op_r;
  logic        swap, neg_r, b_seen, done_r;
  logic [13:0] bin;
  logic [15:0] bcd, bcd_shift;
  logic [3:0]  cnt;
  logic [3:0]  r3, r2, r1, r0;

  logic       is_clear, is_digit, is_oper, is_eq;
  logic [1:0] op_key;
  logic       div_zero, a_lt_b, last_iter;

  // Operator keys 10..13 map to op 0..3 by subtracting 2 modulo 4 on the low bits.
  assign op_key    = key_code[1:0] - 2'd2;
  assign is_clear  = key_valid && (key_code == 4'd15);
  assign is_digit  = key_valid && (key_code <= 4'd9);
  assign is_oper   = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_eq     = key_valid && (key_code == 4'd14);
  assign div_zero  = (op_r == 2'b11) && (b1 == 4'd0) && (b0 == 4'd0);
  assign a_lt_b    = {a1, a0} < {b1, b0};
  assign last_iter = (cnt == 4'd13);

  function automatic logic [15:0] dd_step(input logic [15:0] v, input logic in_bit);
    logic [15:0] adj;
    adj = v;
    for (int i = 0; i < 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return (adj << 1) | {15'd0, in_bit};
  endfunction

  assign bcd_shift = dd_step(bcd, bin[13]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_A;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (is_clear) begin
      state_nx = S_A;
    end else begin
      case (state)
        S_A:     if (is_oper) state_nx = S_B;
        S_B:     if (is_eq) state_nx = div_zero ? S_ERR : S_CALC;
        S_CALC:  state_nx = S_CONV;
        S_CONV:  if (last_iter) state_nx = S_DONE;
        S_DONE,
        S_ERR:   if (is_digit) state_nx = S_A;
        default: state_nx = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1 <= 4'd0; a0 <= 4'd0; b1 <= 4'd0; b0 <= 4'd0;
      op_r <= 2'd0; swap <= 1'b0; neg_r <= 1'b0; b_seen <= 1'b0;
      bin <= 14'd0; bcd <= 16'd0; cnt <= 4'd0;
      r3 <= 4'd0; r2 <= 4'd0; r1 <= 4'd0; r0 <= 4'd0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (is_clear) begin
        a1 <= 4'd0; a0 <= 4'd0; b1 <= 4'd0; b0 <= 4'd0;
        op_r <= 2'd0; swap <= 1'b0; neg_r <= 1'b0; b_seen <= 1'b0;
        r3 <= 4'd0; r2 <= 4'd0; r1 <= 4'd0; r0 <= 4'd0;
      end else begin
        case (state)
          S_A: begin
            if (is_digit) begin
              a1 <= a0;
              a0 <= key_code;
            end else if (is_oper) begin
              op_r   <= op_key;
              b1     <= 4'd0;
              b0     <= 4'd0;
              b_seen <= 1'b0;
            end
          end
          S_B: begin
            if (is_digit) begin
              b1     <= b0;
              b0     <= key_code;
              b_seen <= 1'b1;
            end else if (is_oper && !b_seen) begin
              op_r <= op_key;
            end else if (is_eq) begin
              if (div_zero) begin
                r3 <= 4'd0; r2 <= 4'd0; r1 <= 4'd0; r0 <= 4'd0;
              end else begin
                swap  <= (op_r == 2'b01) && a_lt_b;
                neg_r <= (op_r == 2'b01) && a_lt_b;
              end
            end
          end
          S_CALC: begin
            bin <= num;
            bcd <= 16'd0;
            cnt <= 4'd0;
          end
          S_CONV: begin
            bcd <= bcd_shift;
            bin <= {bin[12:0], 1'b0};
            cnt <= cnt + 4'd1;
            if (last_iter) begin
              r3     <= bcd_shift[15:12];
              r2     <= bcd_shift[11:8];
              r1     <= bcd_shift[7:4];
              r0     <= bcd_shift[3:0];
              done_r <= 1'b1;
            end
          end
          S_DONE, S_ERR: begin
            // A digit starts a fresh calculation with that digit as A.
            if (is_digit) begin
              a1 <= 4'd0; a0 <= key_code;
              b1 <= 4'd0; b0 <= 4'd0;
              swap <= 1'b0; neg_r <= 1'b0; b_seen <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign n2dig1 = swap ? b1 : a1;
  assign n2dig0 = swap ? b0 : a0;
  assign n1dig1 = swap ? a1 : b1;
  assign n1dig0 = swap ? a0 : b0;
  assign op     = op_r;
  assign res3   = r3;
  assign res2   = r2;
  assign res1   = r1;
  assign res0   = r0;
  assign neg    = neg_r;
  assign busy   = (state == S_CALC) || (state == S_CONV);
  assign done   = done_r;
  assign err    = (state == S_ERR);

endmodule
